histogram_cdf_birimi: RTL and testbench

Parametrised successor to the single-frame histogram unit. Holds the whole histogram in an internal 2^PIXEL_BIT x COUNT_BIT memory and accumulates one pixel per clock using a read-modify-write pipeline with forwarding. At frame end it runs an in-place CDF prefix-sum scan, then exposes `cdf_min_o` and a random-access CDF read port to the equalisation stage downstream.

---
 rtl/histogram_cdf_birimi.sv | 177 +++++++++++++++++
 tb/tb_histogram_cdf_birimi.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_cdf_birimi.sv
// histogram_cdf_birimi: per-frame pixel histogram held in an internal 2^PIXEL_BIT x COUNT_BIT
// memory, followed by an in-place saturating CDF prefix-sum scan and a random-access CDF read port.
// Optional clip-limited histogram: define HISTOGRAM_KIRPMA_EN (adds parameter KIRPMA_ESIK).
// Ports: clk_i, rst_i (async, active-high); etkin_i/pixel_i pixel input, hazir_o = accepting;
//        yeni_kare_i restart from BITTI; oku_en_i/oku_addr_i -> oku_veri_o/oku_gecerli_o one
//        cycle later; cdf_min_o first nonzero CDF value; tamam_o = CDF complete and readable.
module histogram_cdf_birimi #(
  parameter int PIXEL_BIT    = 8,
  parameter int COUNT_BIT    = 17,
  parameter int FRAME_PIXELS = 76800
`ifdef HISTOGRAM_KIRPMA_EN
  , parameter int KIRPMA_ESIK = 1024
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 etkin_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  output logic                 hazir_o,
  input  logic                 yeni_kare_i,
  input  logic                 oku_en_i,
  input  logic [PIXEL_BIT-1:0] oku_addr_i,
  output logic [COUNT_BIT-1:0] oku_veri_o,
  output logic                 oku_gecerli_o,
  output logic [COUNT_BIT-1:0] cdf_min_o,
  output logic                 tamam_o
);

  localparam int BINS = 1 << PIXEL_BIT;
  localparam int PW   = $clog2(FRAME_PIXELS + 1);
  localparam logic [PIXEL_BIT:0]   SON_BIN = {1'b0, {PIXEL_BIT{1'b1}}};
  localparam logic [COUNT_BIT-1:0] DOYUM   = {COUNT_BIT{1'b1}};
`ifdef HISTOGRAM_KIRPMA_EN
  // A threshold at or above the counter range can never clip.
  localparam logic [COUNT_BIT-1:0] ESIK =
    (KIRPMA_ESIK >= (2 ** COUNT_BIT)) ? DOYUM : COUNT_BIT'(KIRPMA_ESIK);
`endif

  typedef enum logic [1:0] {TEMIZLE, TOPLA, CDF, BITTI} durum_t;
  durum_t durum, durum_next;

  // Histogram memory: simple dual-port, registered read, read-first on collision.
  logic [COUNT_BIT-1:0] mem [BINS];
  logic [COUNT_BIT-1:0] mem_q;
  logic [PIXEL_BIT-1:0] rd_addr, wr_addr;
  logic                 wr_en;
  logic [COUNT_BIT-1:0] wr_data;

  logic [PIXEL_BIT:0]   sayac;      // bin index for clear and scan; MSB marks scan reads done
  logic [PW-1:0]        pix_sayac;
  logic                 dolu;       // last pixel of the frame accepted
  logic                 kabul;
  logic                 acc_vld, fwd_vld;
  logic [PIXEL_BIT-1:0] acc_addr;
  logic [COUNT_BIT-1:0] fwd_dat;
  logic                 tara_vld;
  logic [PIXEL_BIT-1:0] tara_addr;
  logic [COUNT_BIT-1:0] toplam, toplam_next, cdf_min;
  logic                 oku_vld;
  logic [COUNT_BIT-1:0] oku_tut;
  logic [COUNT_BIT-1:0] bin_cur, bin_inc, bin_kirp;
  logic [COUNT_BIT:0]   toplam_gen;

  assign hazir_o       = (durum == TOPLA) && !dolu;
  assign tamam_o       = (durum == BITTI);
  assign kabul         = hazir_o && etkin_i;
  assign oku_gecerli_o = oku_vld;
  assign oku_veri_o    = oku_vld ? mem_q : oku_tut;
  assign cdf_min_o     = cdf_min;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    mem_q <= mem[rd_addr];
  end

  always_comb begin
    // The memory output is one write stale when the previous pixel hit the same bin.
    bin_cur = fwd_vld ? fwd_dat : mem_q;
    bin_inc = (bin_cur == DOYUM) ? bin_cur : bin_cur + COUNT_BIT'(1);
`ifdef HISTOGRAM_KIRPMA_EN
    bin_kirp = (mem_q > ESIK) ? ESIK : mem_q;
`else
    bin_kirp = mem_q;
`endif
    toplam_gen  = {1'b0, toplam} + {1'b0, bin_kirp};
    toplam_next = toplam_gen[COUNT_BIT] ? DOYUM : toplam_gen[COUNT_BIT-1:0];
  end

  always_comb begin
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (durum)
      TEMIZLE: begin
        wr_en   = 1'b1;
        wr_addr = sayac[PIXEL_BIT-1:0];
      end
      TOPLA:   rd_addr = pixel_i;
      CDF:     rd_addr = sayac[PIXEL_BIT-1:0];
      BITTI:   rd_addr = oku_addr_i;
      default: rd_addr = '0;
    endcase
    if (acc_vld) begin
      wr_en   = 1'b1;
      wr_addr = acc_addr;
      wr_data = bin_inc;
    end else if (tara_vld) begin
      wr_en   = 1'b1;
      wr_addr = tara_addr;
      wr_data = toplam_next;
    end
  end

  always_comb begin
    durum_next = durum;
    case (durum)
      TEMIZLE: if (sayac == SON_BIN) durum_next = TOPLA;
      TOPLA:   if (dolu) durum_next = CDF;
      CDF:     if (tara_vld && (tara_addr == SON_BIN[PIXEL_BIT-1:0])) durum_next = BITTI;
      BITTI:   if (yeni_kare_i) durum_next = TEMIZLE;
      default: durum_next = TEMIZLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum     <= TEMIZLE;
      sayac     <= '0;
      pix_sayac <= '0;
      dolu      <= 1'b0;
      acc_vld   <= 1'b0;
      acc_addr  <= '0;
      fwd_vld   <= 1'b0;
      fwd_dat   <= '0;
      tara_vld  <= 1'b0;
      tara_addr <= '0;
      toplam    <= '0;
      cdf_min   <= '0;
      oku_vld   <= 1'b0;
      oku_tut   <= '0;
    end else begin
      durum     <= durum_next;
      acc_vld   <= kabul;
      acc_addr  <= pixel_i;
      fwd_vld   <= kabul && acc_vld && (acc_addr == pixel_i);
      fwd_dat   <= bin_inc;
      tara_vld  <= (durum == CDF) && !sayac[PIXEL_BIT];
      tara_addr <= sayac[PIXEL_BIT-1:0];
      oku_vld   <= (durum == BITTI) && oku_en_i;
      if (oku_vld) oku_tut <= mem_q;

      if (durum_next != durum)
        sayac <= '0;
      else if ((durum == TEMIZLE) || ((durum == CDF) && !sayac[PIXEL_BIT]))
        sayac <= sayac + (PIXEL_BIT+1)'(1);

      if (durum == TEMIZLE) begin
        pix_sayac <= '0;
        dolu      <= 1'b0;
        toplam    <= '0;
        cdf_min   <= '0;
      end else begin
        if (kabul) begin
          pix_sayac <= pix_sayac + PW'(1);
          if (pix_sayac == PW'(FRAME_PIXELS - 1)) dolu <= 1'b1;
        end
        if (tara_vld) begin
          toplam <= toplam_next;
          // The running sum never decreases, so the first nonzero value is latched once.
          if (cdf_min == '0) cdf_min <= toplam_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_histogram_cdf_birimi.sv
module tb_histogram_cdf_birimi;
  localparam int P  = 8;
  localparam int CA = 17;
  localparam int FA = 16;
  localparam int CB = 4;
  localparam int FB = 20;
`ifdef HISTOGRAM_KIRPMA_EN
  localparam int CLIP_A = 10;
  localparam int CLIP_B = 1024;
`else
  localparam int CLIP_A = 1 << 30;
  localparam int CLIP_B = 1 << 30;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_i, etkin, yeni, oku_en, sel;
  logic [P-1:0] pixel, oku_addr;

  logic          hazir_a, gec_a, tamam_a;
  logic [CA-1:0] veri_a, min_a;
  logic          hazir_b, gec_b, tamam_b;
  logic [CB-1:0] veri_b, min_b;

  histogram_cdf_birimi #(.PIXEL_BIT(P), .COUNT_BIT(CA), .FRAME_PIXELS(FA)
`ifdef HISTOGRAM_KIRPMA_EN
    , .KIRPMA_ESIK(CLIP_A)
`endif
  ) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .etkin_i(etkin && !sel), .pixel_i(pixel),
    .hazir_o(hazir_a), .yeni_kare_i(yeni && !sel), .oku_en_i(oku_en && !sel),
    .oku_addr_i(oku_addr), .oku_veri_o(veri_a), .oku_gecerli_o(gec_a),
    .cdf_min_o(min_a), .tamam_o(tamam_a)
  );

  histogram_cdf_birimi #(.PIXEL_BIT(P), .COUNT_BIT(CB), .FRAME_PIXELS(FB)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .etkin_i(etkin && sel), .pixel_i(pixel),
    .hazir_o(hazir_b), .yeni_kare_i(yeni && sel), .oku_en_i(oku_en && sel),
    .oku_addr_i(oku_addr), .oku_veri_o(veri_b), .oku_gecerli_o(gec_b),
    .cdf_min_o(min_b), .tamam_o(tamam_b)
  );

  logic          hazir, gecerli, tamam;
  logic [CA-1:0] veri, cdf_min;
  assign hazir   = sel ? hazir_b : hazir_a;
  assign gecerli = sel ? gec_b   : gec_a;
  assign tamam   = sel ? tamam_b : tamam_a;
  assign veri    = sel ? {{(CA-CB){1'b0}}, veri_b} : veri_a;
  assign cdf_min = sel ? {{(CA-CB){1'b0}}, min_b}  : min_a;

  int checks   = 0;
  int failures = 0;
  int exp_cdf[256];
  int exp_min;
  int last_exp;
  int exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: count, clamp to counter range, clip, saturating prefix sum.
  task automatic model(input int px[$], input int cb, input int clip);
    int cnt[256];
    int maxv, s;
    maxv = (1 << cb) - 1;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (px[i]) cnt[px[i]]++;
    s = 0;
    exp_min = 0;
    for (int i = 0; i < 256; i++) begin
      int b;
      b = (cnt[i] > maxv) ? maxv : cnt[i];
      if (b > clip) b = clip;
      s = s + b;
      if (s > maxv) s = maxv;
      exp_cdf[i] = s;
      if (exp_min == 0 && s != 0) exp_min = s;
    end
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (!hazir && n < 1000) begin tick(); n++; end
    check(nm, n, 256);
    check("min_cleared", cdf_min, 0);
  endtask

  task automatic run_frame(input int px[$], input int gap_pct, input int extra);
    int n;
    n = 0;
    while (!hazir && n < 1000) begin tick(); n++; end
    check("hazir_ready", hazir, 1);
    foreach (px[i]) begin
      while ($urandom_range(0, 99) < gap_pct) begin etkin = 1'b0; tick(); end
      etkin = 1'b1;
      pixel = P'(px[i]);
      tick();
    end
    etkin = 1'b0;
    check("hazir_drop", hazir, 0);
    n = 1;
    while (!tamam && n < 1000) begin
      etkin = (n >= 3) && (n < 3 + extra);
      pixel = P'($urandom_range(0, 255));
      tick();
      n++;
    end
    etkin = 1'b0;
    check("tamam_latency", n, 259);
    model(px, sel ? CB : CA, sel ? CLIP_B : CLIP_A);
    check("cdf_min", cdf_min, exp_min);
  endtask

  task automatic do_reads(input int addrs[$], input bit yeni_son);
    foreach (addrs[i]) begin
      oku_en   = 1'b1;
      oku_addr = P'(addrs[i]);
      yeni     = yeni_son && (i == addrs.size() - 1);
      exp_q.push_back(exp_cdf[addrs[i]]);
      last_exp = exp_cdf[addrs[i]];
      tick();
    end
    oku_en = 1'b0;
    yeni   = 1'b0;
    if (yeni_son) begin
      check("tamam_drop", tamam, 0);
    end else begin
      tick();
      check("rd_hold_vld", gecerli, 0);
      check("rd_hold_dat", veri, last_exp);
    end
  endtask

  // Scoreboard monitor: every valid read result must match the oldest expectation.
  always @(negedge clk_i) begin
    if (gecerli === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected actual=1 required=0");
      end else begin
        int e;
        e = exp_q.pop_front();
        if (veri !== CA'(e)) begin
          failures++;
          $display("FAIL rd_data actual=%0d required=%0d", veri, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int px[$];
    int ad[$];
    rst_i = 1'b1; etkin = 1'b0; pixel = '0; yeni = 1'b0;
    oku_en = 1'b0; oku_addr = '0; sel = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_hazir", hazir_a, 0);
    check("rst_tamam", tamam_a, 0);
    check("rst_gecerli", gec_a, 0);
    check("rst_veri", veri_a, 0);
    check("rst_cdf_min", min_a, 0);
    check("rst_hazir_b", hazir_b, 0);
    rst_i = 1'b0;
    wait_clear("clear_cycles");

    // Frame 1: all pixels 5
    px = {};
    repeat (FA) px.push_back(5);
    run_frame(px, 0, 0);
    ad = {};
    ad.push_back(0); ad.push_back(4); ad.push_back(5); ad.push_back(6); ad.push_back(255);
    repeat (3) ad.push_back($urandom_range(0, 255));
    do_reads(ad, 1'b0);
    ad = {};
    ad.push_back($urandom_range(0, 255));
    do_reads(ad, 1'b1);
    wait_clear("clear_after_yeni");

    // oku_en outside BITTI is ignored
    oku_en = 1'b1; oku_addr = 8'd5;
    tick();
    oku_en = 1'b0;
    check("rd_ignored", gecerli, 0);

    // Frame 2: back-to-back repeats exercise forwarding
    px = {};
    px.push_back(3); px.push_back(3); px.push_back(3);
    px.push_back(7); px.push_back(3); px.push_back(7);
    repeat (10) px.push_back(200);
    run_frame(px, 0, 0);
    ad = {};
    ad.push_back(3); ad.push_back(7); ad.push_back(200);
    ad.push_back(2); ad.push_back(199); ad.push_back(255);
    do_reads(ad, 1'b1);
    wait_clear("clear_f2");

    // Frame 3: random pixels with gaps, extra pixels during the scan
    px = {};
    repeat (FA) px.push_back($urandom_range(0, 255));
    run_frame(px, 30, 4);
    ad = {};
    ad.push_back(255);
    repeat (8) ad.push_back(px[$urandom_range(0, FA - 1)]);
    do_reads(ad, 1'b1);
    wait_clear("clear_f3");

    // Frame 4: narrow random range, many forwarding hits
    px = {};
    repeat (FA) px.push_back($urandom_range(0, 3));
    run_frame(px, 0, 0);
    ad = {};
    for (int i = 0; i < 5; i++) ad.push_back(i);
    ad.push_back(255);
    do_reads(ad, 1'b1);
    wait_clear("clear_f4");

    // Aborted frame, asynchronous reset mid-cycle
    for (int i = 0; i < 8; i++) begin
      etkin = 1'b1;
      pixel = (i < 4) ? 8'd9 : 8'd3;
      tick();
    end
    etkin = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_hazir", hazir, 0);
    tick();
    tick();
    rst_i = 1'b0;
    wait_clear("clear_after_rst");
    px = {};
    repeat (FA) px.push_back(9);
    run_frame(px, 0, 0);
    ad = {};
    ad.push_back(0); ad.push_back(9); ad.push_back(255);
    do_reads(ad, 1'b0);
    ad = {};
    ad.push_back(3); ad.push_back(0); ad.push_back(9); ad.push_back(255);
    do_reads(ad, 1'b1);
    wait_clear("clear_f5");

    // Narrow counter: saturation
    sel = 1'b1;
    px = {};
    repeat (FB) px.push_back(0);
    run_frame(px, 0, 0);
    ad = {};
    ad.push_back(0); ad.push_back(128); ad.push_back(255);
    do_reads(ad, 1'b1);
    wait_clear("clear_b");

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
